tdc_sum_acc: RTL and testbench

TDC_SUM_ACC -- requirements
Module: tdc_sum_acc

---
 rtl/tdc_pkg.sv | 36 +++
 rtl/tdc_ch_scale.sv | 46 ++++
 rtl/tdc_sum_acc.sv | 218 +++++++++++++++++++++
 tb/tb_tdc_sum_acc.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC channel-sum accumulator.
//   - width helper functions (channel value, adder-tree output, accumulator)
//   - accumulator FSM state type
package tdc_pkg;

  // IDLE: no window open. ACC: a window has started and is collecting shots.
  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } acc_state_t;

  // Width of one scaled channel value int*mult + frac.
  // Largest value is (2^int_w-1)*mult + 2^frac_w - 1, so this many bits hold it.
  function automatic int ch_w_f(input int int_w, input int frac_w, input int mult);
    longint max_plus_one;
    max_plus_one = ((longint'(1) << int_w) - 1) * longint'(mult) + (longint'(1) << frac_w);
    return $clog2(max_plus_one);
  endfunction

  // Adder-tree output: one extra bit per tree level, nothing truncated.
  function automatic int sum_w_f(input int ch_w, input int n_ch);
    return ch_w + $clog2(n_ch);
  endfunction

  // Accumulator wide enough for 2^acc_log2_max tree outputs.
  function automatic int out_w_f(input int sum_w, input int acc_log2_max);
    return sum_w + acc_log2_max;
  endfunction

  // acc_len port width. With acc_log2_max = 0 the natural width would be
  // zero, so a single bit is kept (its value is clamped to 0 internally).
  function automatic int acc_len_w_f(input int acc_log2_max);
    return (acc_log2_max > 0) ? $clog2(acc_log2_max + 1) : 1;
  endfunction

endpackage

// File: rtl/tdc_ch_scale.sv
// Per-channel scaling: ch_val = int_data*COARSE_MULT + frac_data.
// Two register stages: stage 1 holds the product and a delayed copy of
// frac_data, stage 2 holds the sum. A cleared enable (no start, or channel
// masked off) loads zeros, so the downstream tree sees 0 for that slot.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   en         - start AND this channel's mask bit
//   int_data   - coarse count
//   frac_data  - fine interpolator value
//   ch_val     - scaled value, valid two cycles after en
module tdc_ch_scale
  import tdc_pkg::*;
#(
  parameter int INT_W       = 10,
  parameter int FRAC_W      = 7,
  parameter int COARSE_MULT = 50,
  parameter int CH_W        = ch_w_f(INT_W, FRAC_W, COARSE_MULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [INT_W-1:0]  int_data,
  input  logic [FRAC_W-1:0] frac_data,
  output logic [CH_W-1:0]   ch_val
);

  logic [CH_W-1:0]   mult_reg;
  logic [FRAC_W-1:0] frac_reg;
  logic [CH_W-1:0]   val_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_reg <= '0;
      frac_reg <= '0;
      val_reg  <= '0;
    end else begin
      // Product always fits CH_W bits, so the truncating multiply is exact.
      mult_reg <= en ? CH_W'(int_data) * CH_W'(COARSE_MULT) : '0;
      frac_reg <= en ? frac_data : '0;
      val_reg  <= mult_reg + CH_W'(frac_reg);
    end
  end

  assign ch_val = val_reg;

endmodule

// File: rtl/tdc_sum_acc.sv
// TDC channel sum and shot accumulator.
// Each start scales every enabled channel (int*COARSE_MULT + frac), sums
// all channels in a registered binary adder tree, then accumulates
// 2^acc_len consecutive tree outputs into one result. Fully pipelined:
// a start may arrive on every cycle.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   start      - sample strobe for int_data/frac_data/ch_mask
//   int_data   - per-channel coarse counts
//   frac_data  - per-channel fine values
//   ch_mask    - 1 = channel contributes to the sum
//   acc_len    - log2 shots per result, latched at a window's first shot
//   avg_en     - 1 = result is sum >> acc_len, latched with acc_len
//   out_sum    - result, held between strobes
//   out_dval   - one-cycle result strobe
//   out_ovf    - accumulator saturated in the reported window
module tdc_sum_acc
  import tdc_pkg::*;
#(
  parameter  int N_CH         = 16,
  parameter  int INT_W        = 10,
  parameter  int FRAC_W       = 7,
  parameter  int COARSE_MULT  = 50,
  parameter  int ACC_LOG2_MAX = 8,
  localparam int CH_W         = ch_w_f(INT_W, FRAC_W, COARSE_MULT),
  localparam int SUM_W        = sum_w_f(CH_W, N_CH),
  localparam int OUT_W        = out_w_f(SUM_W, ACC_LOG2_MAX),
  localparam int AL_W         = acc_len_w_f(ACC_LOG2_MAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [INT_W-1:0]  int_data  [N_CH],
  input  logic [FRAC_W-1:0] frac_data [N_CH],
  input  logic [N_CH-1:0]   ch_mask,
  input  logic [AL_W-1:0]   acc_len,
  input  logic              avg_en,
  output logic [OUT_W-1:0]  out_sum,
  output logic              out_dval,
  output logic              out_ovf
);

  localparam int LOG2N = $clog2(N_CH);
  localparam int LAT_T = 2 + LOG2N;
  localparam int CNT_W = ACC_LOG2_MAX + 1;

  // ---------------------------------------------------------------- scaling
  logic [CH_W-1:0] ch_val [N_CH];

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      tdc_ch_scale #(
        .INT_W       (INT_W),
        .FRAC_W      (FRAC_W),
        .COARSE_MULT (COARSE_MULT),
        .CH_W        (CH_W)
      ) u_scale (
        .clk       (clk),
        .rst       (rst),
        .en        (start & ch_mask[gi]),
        .int_data  (int_data[gi]),
        .frac_data (frac_data[gi]),
        .ch_val    (ch_val[gi])
      );
    end
  endgenerate

  // ----------------------------------------------------------- adder tree
  // Level gi holds N_CH>>(gi+1) nodes, each CH_W+gi+1 bits wide. Zeros from
  // idle/masked slots flow through, so invalid stages naturally hold 0.
  generate
    for (gi = 0; gi < LOG2N; gi++) begin : g_lvl
      localparam int NW = CH_W + gi + 1;
      localparam int NN = N_CH >> (gi + 1);
      logic [NW-1:0] node [NN];

      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int k = 0; k < NN; k++) node[k] <= '0;
          end else begin
            for (int k = 0; k < NN; k++)
              node[k] <= NW'(ch_val[2*k]) + NW'(ch_val[2*k+1]);
          end
        end
      end else begin : g_rest
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int k = 0; k < NN; k++) node[k] <= '0;
          end else begin
            for (int k = 0; k < NN; k++)
              node[k] <= NW'(g_lvl[gi-1].node[2*k]) + NW'(g_lvl[gi-1].node[2*k+1]);
          end
        end
      end
    end
  endgenerate

  logic [SUM_W-1:0] tree_sum;
  assign tree_sum = g_lvl[LOG2N-1].node[0];

  // Valid bit travels beside the data: bit 0 matches the multiply stage,
  // the top bit matches the tree output.
  logic [LAT_T-1:0] vld_sr_reg;
  logic             tree_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_sr_reg <= '0;
    else     vld_sr_reg <= {vld_sr_reg[LAT_T-2:0], start};
  end

  assign tree_vld = vld_sr_reg[LAT_T-1];

  // ----------------------------------------------------------- accumulator
  acc_state_t       state_reg, state_next;
  logic [OUT_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [AL_W-1:0]  len_reg, len_next;
  logic             avg_reg, avg_next;
  logic             sat_reg, sat_next;
  logic [OUT_W-1:0] out_sum_reg, out_sum_next;
  logic             out_dval_reg, out_dval_next;
  logic             out_ovf_reg, out_ovf_next;

  logic [OUT_W:0]   acc_wide;
  logic [OUT_W-1:0] acc_sat;
  logic [AL_W-1:0]  len_in;
  logic [CNT_W-1:0] cnt_inc;

  assign acc_wide = {1'b0, acc_reg} + (OUT_W+1)'(tree_sum);
  assign acc_sat  = acc_wide[OUT_W] ? '1 : acc_wide[OUT_W-1:0];
  assign cnt_inc  = cnt_reg + CNT_W'(1);
  // Lengths beyond the accumulator's capacity are clamped to the maximum.
  assign len_in   = (acc_len > AL_W'(ACC_LOG2_MAX)) ? AL_W'(ACC_LOG2_MAX) : acc_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    cnt_next      = cnt_reg;
    len_next      = len_reg;
    avg_next      = avg_reg;
    sat_next      = sat_reg;
    out_sum_next  = out_sum_reg;
    out_dval_next = 1'b0;
    out_ovf_next  = out_ovf_reg;

    case (state_reg)
      IDLE: begin
        if (tree_vld) begin
          if (len_in == '0) begin
            // Single-shot window: shifting by zero makes avg_en irrelevant.
            out_sum_next  = OUT_W'(tree_sum);
            out_dval_next = 1'b1;
            out_ovf_next  = 1'b0;
          end else begin
            acc_next   = OUT_W'(tree_sum);
            len_next   = len_in;
            avg_next   = avg_en;
            cnt_next   = CNT_W'(1);
            sat_next   = 1'b0;
            state_next = ACC;
          end
        end
      end
      ACC: begin
        if (tree_vld) begin
          if (cnt_inc == (CNT_W'(1) << len_reg)) begin
            out_sum_next  = avg_reg ? (acc_sat >> len_reg) : acc_sat;
            out_ovf_next  = sat_reg | acc_wide[OUT_W];
            out_dval_next = 1'b1;
            acc_next      = '0;
            cnt_next      = '0;
            sat_next      = 1'b0;
            state_next    = IDLE;
          end else begin
            acc_next = acc_sat;
            cnt_next = cnt_inc;
            sat_next = sat_reg | acc_wide[OUT_W];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg      <= '0;
      cnt_reg      <= '0;
      len_reg      <= '0;
      avg_reg      <= 1'b0;
      sat_reg      <= 1'b0;
      out_sum_reg  <= '0;
      out_dval_reg <= 1'b0;
      out_ovf_reg  <= 1'b0;
    end else begin
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      len_reg      <= len_next;
      avg_reg      <= avg_next;
      sat_reg      <= sat_next;
      out_sum_reg  <= out_sum_next;
      out_dval_reg <= out_dval_next;
      out_ovf_reg  <= out_ovf_next;
    end
  end

  assign out_sum  = out_sum_reg;
  assign out_dval = out_dval_reg;
  assign out_ovf  = out_ovf_reg;

endmodule

// File: tb/tb_tdc_sum_acc.sv
// Testbench for tdc_sum_acc: directed cases plus randomized shots, checked
// by a scoreboard fed from a shot-level reference model.
module tb_tdc_sum_acc;

  localparam int N   = 16;
  localparam int LAT = $clog2(N) + 3;  // start -> out_dval, in cycles

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  int_data  [N];
  logic [6:0]  frac_data [N];
  logic [15:0] ch_mask;
  logic [3:0]  acc_len;
  logic        avg_en;
  logic [27:0] out_sum;
  logic        out_dval;
  logic        out_ovf;

  // Second instance: single-shot only, all inputs at maximum.
  logic        start2;
  logic [9:0]  int2  [N];
  logic [6:0]  frac2 [N];
  logic [15:0] mask2;
  logic        acc_len2;
  logic        avg2;
  logic [19:0] out_sum2;
  logic        out_dval2;
  logic        out_ovf2;

  always #5 clk = ~clk;

  tdc_sum_acc dut (
    .clk(clk), .rst(rst), .start(start), .int_data(int_data), .frac_data(frac_data),
    .ch_mask(ch_mask), .acc_len(acc_len), .avg_en(avg_en),
    .out_sum(out_sum), .out_dval(out_dval), .out_ovf(out_ovf)
  );

  tdc_sum_acc #(.INT_W(10), .COARSE_MULT(50), .ACC_LOG2_MAX(0)) dut_max (
    .clk(clk), .rst(rst), .start(start2), .int_data(int2), .frac_data(frac2),
    .ch_mask(mask2), .acc_len(acc_len2), .avg_en(avg2),
    .out_sum(out_sum2), .out_dval(out_dval2), .out_ovf(out_ovf2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ------------------------------------------------------------ ref model
  typedef struct {
    longint sum;
    int     cyc;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   exp2_q[$];
  longint last_sum = 0;

  int     win_cnt = 0;
  int     win_len = 0;
  bit     win_avg = 1'b0;
  longint win_acc = 0;

  function automatic longint shot_sum(input logic [15:0] m);
    longint s = 0;
    for (int c = 0; c < N; c++)
      if (m[c]) s += longint'(int_data[c]) * 50 + longint'(frac_data[c]);
    return s;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue one shot; the model latches acc_len/avg_en at a window's first shot
  // and queues a result when 2^len shots have been collected.
  task automatic shot(input logic [15:0] m, input bit rnd, input int iv, input int fv);
    exp_t e;
    for (int c = 0; c < N; c++) begin
      int_data[c]  = rnd ? 10'($urandom_range(1023)) : 10'(iv);
      frac_data[c] = rnd ? 7'($urandom_range(127))   : 7'(fv);
    end
    ch_mask = m;
    start   = 1'b1;
    if (win_cnt == 0) begin
      win_len = int'(acc_len);
      win_avg = avg_en;
    end
    win_acc += shot_sum(m);
    win_cnt++;
    if (win_cnt == (1 << win_len)) begin
      e.sum = win_avg ? (win_acc >> win_len) : win_acc;
      e.cyc = cyc + LAT;
      exp_q.push_back(e);
      win_cnt = 0;
      win_acc = 0;
    end
    wait_cycles(1);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (exp_q.size() != 0 || exp2_q.size() != 0); i++)
      wait_cycles(1);
    check("drain_pending", exp_q.size() + exp2_q.size(), 0);
    wait_cycles(4);
  endtask

  // --------------------------------------------------------------- monitors
  always @(negedge clk) begin
    if (rst) begin
      last_sum = 0;
    end else if (out_dval) begin
      if (exp_q.size() == 0) begin
        check("unexpected_dval", longint'(out_sum), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_txn++;
        $display("txn %0d: out_sum=%0d expected=%0d cycle=%0d", n_txn, out_sum, e.sum, cyc);
        check("out_sum", longint'(out_sum), e.sum);
        check("latency", cyc, e.cyc);
        check("out_ovf", longint'(out_ovf), 0);
        last_sum = e.sum;
      end
    end else begin
      check("hold_out_sum", longint'(out_sum), last_sum);
    end
  end

  always @(negedge clk) begin
    if (!rst && out_dval2) begin
      if (exp2_q.size() == 0) begin
        check("unexpected_dval2", longint'(out_sum2), -1);
      end else begin
        exp_t e;
        e = exp2_q.pop_front();
        $display("txn max: out_sum=%0d expected=%0d cycle=%0d", out_sum2, e.sum, cyc);
        check("max_out_sum", longint'(out_sum2), e.sum);
        check("max_latency", cyc, e.cyc);
        check("max_out_ovf", longint'(out_ovf2), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  // -------------------------------------------------------------- stimulus
  initial begin
    exp_t e;
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    ch_mask = '0; acc_len = '0; avg_en = 1'b0;
    acc_len2 = 1'b0; avg2 = 1'b0; mask2 = 16'hFFFF;
    for (int c = 0; c < N; c++) begin
      int_data[c] = '0; frac_data[c] = '0;
      int2[c] = 10'h3FF; frac2[c] = 7'h7F;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_sum",  longint'(out_sum),  0);
    check("reset_out_dval", longint'(out_dval), 0);
    check("reset_out_ovf",  longint'(out_ovf),  0);
    rst = 1'b0;
    wait_cycles(2);

    // Single shots, acc_len = 0: full mask, low nibble, nothing.
    shot(16'hFFFF, 1'b0, 1, 2); drain();
    shot(16'h000F, 1'b0, 1, 2); drain();
    shot(16'h0000, 1'b0, 1, 2); drain();

    // Four-shot window, plain sum then averaged.
    acc_len = 4'd2;
    avg_en  = 1'b0;
    repeat (4) shot(16'hFFFF, 1'b0, 1, 2);
    drain();
    avg_en = 1'b1;
    repeat (4) shot(16'hFFFF, 1'b0, 1, 2);
    drain();

    // 100 back-to-back random single shots.
    acc_len = 4'd0;
    avg_en  = 1'b0;
    repeat (100) shot(16'($urandom), 1'b1, 0, 0);
    drain();

    // acc_len/avg_en changed mid-window must not affect the open window.
    acc_len = 4'd2;
    avg_en  = 1'b0;
    shot(16'hFFFF, 1'b1, 0, 0);
    wait_cycles(8);
    acc_len = 4'd0;
    avg_en  = 1'b1;
    repeat (3) shot(16'($urandom), 1'b1, 0, 0);
    drain();

    // Random window lengths with random gaps between shots.
    for (int rep = 0; rep < 6; rep++) begin
      acc_len = 4'($urandom_range(3, 1));
      avg_en  = 1'($urandom_range(1));
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < (1 << acc_len); s++) begin
          shot(16'($urandom), 1'b1, 0, 0);
          wait_cycles($urandom_range(2));
        end
      drain();
    end

    // Reset mid-window: two of four shots issued, one already in the window,
    // one still in the pipeline.
    acc_len = 4'd2;
    avg_en  = 1'b0;
    repeat (2) shot(16'hFFFF, 1'b0, 1, 2);
    wait_cycles(5);
    rst = 1'b1;
    #1;
    check("midrst_out_sum",  longint'(out_sum),  0);
    check("midrst_out_dval", longint'(out_dval), 0);
    check("midrst_out_ovf",  longint'(out_ovf),  0);
    win_cnt = 0;
    win_acc = 0;
    exp_q.delete();
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(15);
    repeat (4) shot(16'($urandom), 1'b1, 0, 0);
    drain();

    // All-max inputs on the single-shot instance.
    e.sum = 0;
    for (int c = 0; c < N; c++) e.sum += longint'(int2[c]) * 50 + longint'(frac2[c]);
    e.cyc = cyc + LAT;
    exp2_q.push_back(e);
    start2 = 1'b1;
    wait_cycles(1);
    start2 = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
